// File: rtl/uart_pkg.sv
// uart_pkg: shared UART framing constants and transmitter FSM encoding
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 217;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} tx_state_e;
endpackage

// File: rtl/transmitter_if.sv
// transmitter_if: byte-write handshake and serial line status of the UART transmitter
interface transmitter_if;
  import uart_pkg::*;
  logic                      Tx_DV_in;
  logic [UART_DATA_BITS-1:0] Tx_Byte_in;
  logic                      Tx_Ready_out;
  logic                      Tx_Serial_out;
  logic                      Tx_Active_out;
  logic                      Tx_Done_out;
  modport master(output Tx_DV_in, Tx_Byte_in, input Tx_Ready_out, Tx_Serial_out, Tx_Active_out, Tx_Done_out);
  modport slave(input Tx_DV_in, Tx_Byte_in, output Tx_Ready_out, Tx_Serial_out, Tx_Active_out, Tx_Done_out);
endinterface

// File: rtl/tx_fifo.sv
// tx_fifo: first-word-fall-through byte FIFO with registered occupancy count
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q;
  logic do_wr, do_rd;
  assign full = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  // full gates the write even when a pop frees a slot this cycle
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q];
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end
  always_ff @(posedge CLK) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/transmitter.sv
// transmitter: FIFO-buffered UART transmitter, 8N1, LSB first
module transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input logic CLK,
  input logic RST,
  transmitter_if.slave tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(UART_DATA_BITS - 1);
  tx_state_e state_q;
  logic [CW-1:0] clk_cnt_q;
  logic [BW-1:0] bit_idx_q;
  logic [UART_DATA_BITS-1:0] shift_q, fifo_data;
  logic serial_q, active_q, done_q;
  logic fifo_full, fifo_empty, pop, cnt_end;
  assign pop = state_q == IDLE && !fifo_empty;
  assign cnt_end = clk_cnt_q == CNT_MAX;
  assign tx.Tx_Ready_out = !fifo_full;
  assign tx.Tx_Serial_out = serial_q;
  assign tx.Tx_Active_out = active_q;
  assign tx.Tx_Done_out = done_q;
  tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(UART_DATA_BITS)) u_fifo (
    .CLK(CLK), .RST(RST),
    .wr_en(tx.Tx_DV_in), .wr_data(tx.Tx_Byte_in),
    .rd_en(pop), .rd_data(fifo_data),
    .full(fifo_full), .empty(fifo_empty)
  );
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q <= '0;
      serial_q <= STOP_BIT;
      active_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          serial_q <= pop ? START_BIT : STOP_BIT;
          clk_cnt_q <= '0;
          if (pop) begin
            shift_q <= fifo_data;
            bit_idx_q <= '0;
            active_q <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          clk_cnt_q <= cnt_end ? '0 : clk_cnt_q + 1'b1;
          if (cnt_end) begin
            serial_q <= shift_q[0];
            bit_idx_q <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          clk_cnt_q <= cnt_end ? '0 : clk_cnt_q + 1'b1;
          if (cnt_end) begin
            bit_idx_q <= bit_idx_q == BIT_MAX ? bit_idx_q : bit_idx_q + 1'b1;
            serial_q <= bit_idx_q == BIT_MAX ? STOP_BIT : shift_q[bit_idx_q + 1'b1];
            state_q <= bit_idx_q == BIT_MAX ? STOP : DATA;
          end
        end
        STOP: begin
          clk_cnt_q <= cnt_end ? '0 : clk_cnt_q + 1'b1;
          if (cnt_end) begin
            done_q <= 1'b1;
            active_q <= 1'b0;
            state_q <= CLEANUP;
          end
        end
        CLEANUP: begin
          done_q <= 1'b0;
          serial_q <= STOP_BIT;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_transmitter.sv
// tb_transmitter: scoreboard bench; a line monitor decodes frames and checks them against queued bytes
module tb_transmitter;
  typedef struct {
    logic [7:0] data;
    int         start;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int n_frames = 0;
  int done_cnt = 0;
  int last_k = 0;
  exp_t sb[$];
  transmitter_if tif();
  transmitter #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (.CLK(clk), .RST(rst), .tx(tif.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!rst && tif.Tx_Done_out) done_cnt++;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask
  // exp_start: -2 = start one edge after the accepting edge, -1 = unchecked, else absolute edge
  task automatic wr(input logic [7:0] b, input int exp_start, input bit push);
    exp_t e;
    tif.Tx_DV_in = 1'b1;
    tif.Tx_Byte_in = b;
    last_k = cyc + 1;
    if (push) begin
      chk("wr_ready", 32'(tif.Tx_Ready_out), 32'd1);
      e.data = b;
      e.start = exp_start == -2 ? last_k + 1 : exp_start;
      sb.push_back(e);
    end
    @(negedge clk);
    tif.Tx_DV_in = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || tif.Tx_Active_out || tif.Tx_Done_out) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("idle_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask
  initial begin : monitor
    logic [9:0] bits;
    bit glitch, aborted;
    int s;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && tif.Tx_Serial_out == 1'b0) begin
        s = cyc;
        glitch = 0;
        aborted = 0;
        bits = '0;
        for (int i = 0; i < 40; i++) begin
          if (i > 0) @(negedge clk);
          if (rst) begin
            aborted = 1;
            break;
          end
          if (i % 4 == 0) bits[i/4] = tif.Tx_Serial_out;
          else if (tif.Tx_Serial_out != bits[i/4]) glitch = 1;
          if (!tif.Tx_Active_out || tif.Tx_Done_out) glitch = 1;
        end
        if (!aborted) begin
          @(negedge clk);
          chk("done_pulse", {tif.Tx_Done_out, tif.Tx_Active_out}, 2'b10);
          @(negedge clk);
          chk("done_clear", 32'(tif.Tx_Done_out), 32'd0);
          n_frames++;
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL extra_frame: got byte %02h, required no frame", bits[8:1]);
          end else begin
            e = sb.pop_front();
            chk("frame_data", 32'(bits[8:1]), 32'(e.data));
            chk("framing", {bits[0], bits[9], glitch}, 3'b010);
            if (e.start >= 0) chk("start_edge", s, e.start);
          end
        end
      end
    end
  end
  initial begin
    int s0, n;
    tif.Tx_DV_in = 1'b0;
    tif.Tx_Byte_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_line", {tif.Tx_Serial_out, tif.Tx_Active_out, tif.Tx_Done_out, tif.Tx_Ready_out}, 4'b1001);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    wr(8'h55, -2, 1);
    wait_idle();
    wr(8'hA1, -2, 1);
    s0 = last_k + 1;
    wr(8'hA2, s0 + 42, 1);
    wr(8'hA3, s0 + 84, 1);
    wr(8'hA4, s0 + 126, 1);
    wr(8'hA5, s0 + 168, 1);
    chk("full_ready", 32'(tif.Tx_Ready_out), 32'd0);
    wr(8'hEE, -1, 0);
    while (cyc < s0 + 41) @(negedge clk);
    chk("full_pop_ready", 32'(tif.Tx_Ready_out), 32'd0);
    wr(8'hEE, -1, 0);
    chk("after_pop_ready", 32'(tif.Tx_Ready_out), 32'd1);
    wait_idle();
    wr(8'h00, -2, 1);
    s0 = last_k + 1;
    wr(8'hFF, s0 + 42, 1);
    wait_idle();
    wr(8'h3C, -2, 0);
    s0 = last_k + 1;
    wr(8'h77, -1, 0);
    while (cyc < s0 + 17) @(negedge clk);
    #1 rst = 1'b1;
    #1 chk("async_rst", {tif.Tx_Serial_out, tif.Tx_Active_out, tif.Tx_Ready_out}, 3'b101);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst", {tif.Tx_Serial_out, tif.Tx_Active_out, tif.Tx_Done_out}, 3'b100);
    wr(8'h81, -2, 1);
    wait_idle();
    for (int b = 0; b < 256; b++) begin
      n = 0;
      while (!tif.Tx_Ready_out && n < 1000) begin
        @(negedge clk);
        n++;
      end
      wr(8'(b), -1, 1);
    end
    wait_idle();
    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    chk("done_count", done_cnt, n_frames);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
